// File: rtl/package_bus.sv
// package_bus: bus-side packet type; adr occupies the upper half so a t_str word casts straight onto it.
package package_bus;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } t_bus;
endpackage

// File: rtl/package_str.sv
// package_str: stream-side types shared by the bus/stream multiplexer pair.
package package_str;
  localparam int PKT_BYTES = 8;
  typedef logic [PKT_BYTES-1:0][7:0] t_str;
endpackage

// File: rtl/systemverilog_str_timeout.sv
// systemverilog_str_timeout: idle counter that expires a stalled partial packet.
//   clk, rst (sync, active-low) | partial: assembly holds 1..PKT_BYTES-1 bytes
//   acc: a byte is accepted this cycle | expire: discard the partial packet on the next edge
//   drop: registered one-cycle pulse following an expiry
module systemverilog_str_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic partial,
  input  logic acc,
  output logic expire,
  output logic drop
);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT);
  logic [15:0] idle_q, idle_d;
  logic drop_q, drop_d;
  always_comb begin
    expire = partial & ~acc & (idle_q == LIMIT);
    idle_d = (~partial | acc | expire) ? '0 : idle_q + 16'd1;
    drop_d = expire;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_q <= '0;
      drop_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      drop_q <= drop_d;
    end
  end
  assign drop = drop_q;
endmodule

// File: rtl/systemverilog_str_demux.sv
// systemverilog_str_demux: assembles 8 stream bytes into one 32-bit bus write (adr + dat).
//   clk, rst (sync, active-low)
//   str_vld/str_bus[7:0]/str_rdy: byte stream in | bus_vld/bus_adr[31:0]/bus_dat[31:0]/bus_rdy: bus write out
//   drop: timeout discard pulse, only with STR_DEMUX_TIMEOUT_EN defined (otherwise tied 0)
module systemverilog_str_demux #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        str_vld,
  input  logic [7:0]  str_bus,
  output logic        str_rdy,
  output logic        bus_vld,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic        bus_rdy,
  output logic        drop
);
  import package_bus::*;
  import package_str::*;
  localparam int CW = $clog2(PKT_BYTES + 1);
  localparam int IW = $clog2(PKT_BYTES);
  localparam logic [CW-1:0] FULL = CW'(PKT_BYTES);
  logic [CW-1:0] cnt_q, cnt_d;
  t_str asm_q, asm_d;
  t_bus out_q, out_d;
  logic vld_q, vld_d;
  logic full, acc, load, expire;
  assign full = cnt_q == FULL;
  assign acc  = str_vld & ~full;
  assign load = full & (~vld_q | bus_rdy);
`ifdef STR_DEMUX_TIMEOUT_EN
  logic partial;
  assign partial = (cnt_q != '0) & ~full;
  systemverilog_str_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .partial (partial),
    .acc     (acc),
    .expire  (expire),
    .drop    (drop)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
  assign drop   = 1'b0;
`endif
  always_comb begin
    cnt_d = (load | expire) ? '0 : acc ? cnt_q + CW'(1) : cnt_q;
    asm_d = asm_q;
    if (acc) asm_d[cnt_q[IW-1:0]] = str_bus;
    out_d = load ? t_bus'(asm_q) : out_q;
    vld_d = load | (vld_q & ~bus_rdy);
  end
  // The assembly register carries no reset: cnt alone decides which lanes are meaningful.
  always_ff @(posedge clk) asm_q <= asm_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end
  assign str_rdy = ~full;
  assign bus_vld = vld_q;
  assign bus_adr = out_q.adr;
  assign bus_dat = out_q.dat;
endmodule

// File: tb/tb_systemverilog_str_demux.sv
// tb_systemverilog_str_demux: directed and random checks of the stream-to-bus demultiplexer.
module tb_systemverilog_str_demux;
  logic clk = 1'b0, rst = 1'b0, str_vld = 1'b0, bus_rdy = 1'b0;
  logic [7:0] str_bus = 8'h00;
  logic str_rdy, bus_vld, drop;
  logic [31:0] bus_adr, bus_dat;
  int n_chk = 0, n_fail = 0, n_xfer = 0, n_drop = 0;
  bit acc_f;
  logic [7:0] src_q[$], bytes_q[$];
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  systemverilog_str_demux #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .str_vld (str_vld),
    .str_bus (str_bus),
    .str_rdy (str_rdy),
    .bus_vld (bus_vld),
    .bus_adr (bus_adr),
    .bus_dat (bus_dat),
    .bus_rdy (bus_rdy),
    .drop    (drop)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One clock: observe handshakes mid-cycle, update the reference model, then step past the edge.
  task automatic tick();
    logic [63:0] w;
    @(negedge clk);
    if (drop) begin
      n_drop++;
      bytes_q.delete();
    end
    acc_f = str_vld && str_rdy;
    if (acc_f) begin
      bytes_q.push_back(str_bus);
      if (bytes_q.size() == 8) begin
        for (int i = 0; i < 8; i++) w[8*i +: 8] = bytes_q[i];
        exp_q.push_back(w);
        bytes_q.delete();
      end
    end
    if (bus_vld && bus_rdy) begin
      n_xfer++;
      if (exp_q.size() == 0) check("unexpected_write", {bus_adr, bus_dat}, 64'hx);
      else begin
        w = exp_q.pop_front();
        check("bus_word", {bus_adr, bus_dat}, w);
      end
    end
    @(posedge clk);
    #1;
  endtask
  // Offer queued bytes for a fixed number of cycles, or until the queue empties (bounded).
  task automatic feed(input int cycles, input bit until_empty);
    int n = 0;
    while (until_empty ? (src_q.size() > 0 && n < 1000) : n < cycles) begin
      str_vld = src_q.size() > 0;
      str_bus = src_q.size() > 0 ? src_q[0] : 8'h00;
      tick();
      if (acc_f) void'(src_q.pop_front());
      n++;
    end
    str_vld = 1'b0;
    if (until_empty) check("feed_drained", 64'(src_q.size()), 64'd0);
  endtask
  task automatic wait_vld();
    int n = 0;
    while (!bus_vld && n < 30) begin
      tick();
      n++;
    end
    check("bus_vld_seen", 64'(bus_vld), 64'd1);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    str_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bytes_q.delete();
    exp_q.delete();
    src_q.delete();
  endtask
  initial begin
    int x0, d0, lat;
    logic [63:0] held;
    do_reset();
    check("rst_str_rdy", 64'(str_rdy), 64'd1);
    check("rst_bus_vld", 64'(bus_vld), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_bus_word", {bus_adr, bus_dat}, 64'd0);
    // single packet and its latency
    bus_rdy = 1'b1;
    x0 = n_xfer;
    foreach (src_q[i]) ;
    src_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    feed(0, 1);
    lat = 1;
    while (!bus_vld && lat < 20) begin
      tick();
      lat++;
    end
    check("single_latency", 64'(lat), 64'd2);
    check("single_adr", 64'(bus_adr), 64'hDEADBEEF);
    check("single_dat", 64'(bus_dat), 64'h12345678);
    repeat (3) tick();
    check("single_count", 64'(n_xfer - x0), 64'd1);
    check("single_vld_clear", 64'(bus_vld), 64'd0);
    // back-pressure: three packets offered against a stalled bus
    bus_rdy = 1'b0;
    x0 = n_xfer;
    repeat (24) src_q.push_back(8'($urandom));
    feed(40, 0);
    check("bp_bus_vld", 64'(bus_vld), 64'd1);
    check("bp_str_rdy", 64'(str_rdy), 64'd0);
    check("bp_bytes_left", 64'(src_q.size()), 64'd8);
    check("bp_pending", 64'(exp_q.size()), 64'd2);
    held = exp_q[0];
    check("bp_held_word", {bus_adr, bus_dat}, held);
    bus_rdy = 1'b1;
    feed(60, 0);
    check("bp_count", 64'(n_xfer - x0), 64'd3);
    check("bp_all_out", 64'(exp_q.size()), 64'd0);
    // streaming: one packet every 9 cycles
    repeat (200) src_q.push_back(8'($urandom));
    feed(18, 0);
    x0 = n_xfer;
    feed(90, 0);
    check("stream_rate", 64'(n_xfer - x0), 64'd10);
    feed(0, 1);
    repeat (4) tick();
    check("stream_all_out", 64'(exp_q.size()), 64'd0);
    // stalled partial packet
    d0 = n_drop;
    x0 = n_xfer;
    src_q = '{8'hA1, 8'hA2, 8'hA3};
    feed(0, 1);
    repeat (20) tick();
`ifdef STR_DEMUX_TIMEOUT_EN
    check("timeout_drop", 64'(n_drop - d0), 64'd1);
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    feed(0, 1);
    wait_vld();
    check("timeout_dat", 64'(bus_dat), 64'h04030201);
    check("timeout_adr", 64'(bus_adr), 64'h08070605);
`else
    check("wait_no_drop", 64'(n_drop - d0), 64'd0);
    check("wait_no_write", 64'(n_xfer - x0), 64'd0);
    src_q = '{8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
    feed(0, 1);
    wait_vld();
    check("wait_dat", 64'(bus_dat), 64'hB4A3A2A1);
    check("wait_adr", 64'(bus_adr), 64'hB8B7B6B5);
`endif
    repeat (3) tick();
    // reset mid-packet
    repeat (5) src_q.push_back(8'($urandom));
    feed(0, 1);
    d0 = n_drop;
    x0 = n_xfer;
    do_reset();
    check("midrst_str_rdy", 64'(str_rdy), 64'd1);
    check("midrst_bus_vld", 64'(bus_vld), 64'd0);
    repeat (8) src_q.push_back(8'($urandom));
    feed(0, 1);
    wait_vld();
    repeat (3) tick();
    check("midrst_count", 64'(n_xfer - x0), 64'd1);
    check("midrst_no_drop", 64'(n_drop - d0), 64'd0);
    check("final_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
